ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/npc_pkg.sv | 18 +
 rtl/ifu_if.sv | 27 ++
 rtl/ifu_fifo.sv | 65 ++++++
 rtl/ifu.sv | 132 +++++++++++++
 tb/tb_ifu.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// Shared fetch-side types and constants: data widths, the reset PC and the IFU state enum.
package npc_pkg;

    localparam int              XLEN             = 64;
    localparam int              ILEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef enum logic {
        IFU_RUN   = 1'b0,
        IFU_DRAIN = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory request/response bus between the IFU (master) and memory (slave).
interface ifu_if;
    import npc_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/ifu_fifo.sv
// Power-of-two FIFO holding fetched instructions; head is visible on rdata, flush empties it.
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: sequential fetch, buffered delivery, redirect flush with stale-response drain.
// Optional performance counters are built when IFU_PERF_EN is defined.
module ifu
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    ifu_if.master           imem,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt
`endif
);
    localparam int FCW = $clog2(BUF_DEPTH) + 1;
    localparam int CW  = FCW + 1;

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   inflight;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_full, fifo_empty;
    logic            req_fire, resp_keep, pop;
    logic [XLEN-1:0] redirect_pc_al;
    fetch_entry_t    push_entry, head_entry;

    assign redirect_pc_al = redirect_pc & ~XLEN'(3);
    // Stale responses still occupy the memory pipe, so they count against the slot budget.
    assign inflight       = CW'(fifo_count) + outst_q + discard_q;
    assign imem.imem_req_valid = rst_n && !redirect_valid && !fifo_full
                                 && (inflight < CW'(BUF_DEPTH));
    assign imem.imem_req_addr  = pc_q;
    assign req_fire   = imem.imem_req_valid && imem.imem_req_ready;
    assign resp_keep  = imem.imem_resp_valid && !redirect_valid && (state_q == IFU_RUN);
    assign push_entry = '{pc: resp_pc_q, inst: imem.imem_resp_data};

    assign inst_valid = !fifo_empty && !redirect_valid;
    assign inst       = fifo_empty ? '0 : head_entry.inst;
    assign inst_pc    = fifo_empty ? '0 : head_entry.pc;
    assign pop        = inst_valid && inst_ready;

    ifu_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (resp_keep),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            pc_d      = redirect_pc_al;
            resp_pc_d = redirect_pc_al;
            outst_d   = '0;
            discard_d = outst_q + discard_q - CW'(imem.imem_resp_valid);
            state_d   = (discard_d != '0) ? IFU_DRAIN : IFU_RUN;
        end else begin
            if (req_fire)  pc_d      = pc_q + XLEN'(4);
            if (resp_keep) resp_pc_d = resp_pc_q + XLEN'(4);
            outst_d = outst_q + CW'(req_fire) - CW'(resp_keep);
            if (state_q == IFU_DRAIN && imem.imem_resp_valid) begin
                discard_d = discard_q - CW'(1);
                if (discard_q == CW'(1)) state_d = IFU_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IFU_RUN;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_q, perf_fetch_d;
    logic [63:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 64'(req_fire);
        perf_stall_d = perf_stall_q + 64'(inst_valid && !inst_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: cycle table after reset plus stall, hold, redirect and wrap sequences.
module tb_ifu;
    import npc_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ifu_if bus();

    ifu #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct { logic [63:0] addr; int due; } mreq_t;
    typedef struct {
        logic        ready;
        logic        exp_rv;
        logic [63:0] exp_addr;
        logic        exp_iv;
        logic [63:0] exp_ipc;
    } vec_t;

    int          pass_cnt = 0, total_cnt = 0;
    int          cyc, mem_lat, fires, consumed, stalls;
    mreq_t       mq[$];
    logic [63:0] fire_log[$];
    logic [63:0] exp_pc, nf_exp, last_pc;
    logic        s_rv, s_iv;
    logic [63:0] s_addr, s_ipc;
    vec_t        tbl[7];

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_1234 ^ {a[63:48], 16'h0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    // One clock: sample at negedge, score, then present memory responses after the edge.
    task automatic step();
        @(negedge clk);
        s_rv = bus.imem_req_valid; s_addr = bus.imem_req_addr;
        s_iv = inst_valid;         s_ipc  = inst_pc;
        if (s_rv && bus.imem_req_ready) begin
            check("req_addr_seq", s_addr, nf_exp);
            nf_exp = s_addr + 64'd4;
            mq.push_back('{addr: s_addr, due: cyc + mem_lat});
            fire_log.push_back(s_addr);
            fires++;
        end
        if (inst_valid && !inst_ready) stalls++;
        if (redirect_valid) begin
            check("redir_inst_valid", {63'd0, s_iv}, 64'd0);
            check("redir_req_valid", {63'd0, s_rv}, 64'd0);
            exp_pc = {redirect_pc[63:2], 2'b00};
            nf_exp = exp_pc;
        end else if (s_iv && inst_ready) begin
            check("deliv_pc", s_ipc, exp_pc);
            check("deliv_inst", {32'd0, inst}, {32'd0, mdata(exp_pc)});
            last_pc = s_ipc;
            exp_pc  = exp_pc + 64'd4;
            consumed++;
        end
        @(posedge clk); #1;
        cyc++;
        bus.imem_resp_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            mreq_t m;
            m = mq.pop_front();
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mdata(m.addr);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b1; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
        inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mq.delete(); fire_log.delete(); mem_lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst", {32'd0, inst}, 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
`ifdef IFU_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 64'd0);
        check("rst_perf_stall", perf_stall_cnt, 64'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1; cyc = 0; exp_pc = RST_PC; nf_exp = RST_PC;
        fires = 0; consumed = 0; stalls = 0;
    endtask

    task automatic wait_delivery(input string name, input logic [63:0] want, input int budget);
        int c0, n;
        c0 = consumed; n = 0;
        while (consumed == c0 && n < budget) begin step(); n++; end
        if (consumed == c0) check({name, "_timeout"}, 64'd0, 64'd1);
        else check(name, last_pc, want);
    endtask

    task automatic drain_mem(input int lat);
        int n;
        n = 0;
        bus.imem_req_ready = 1'b0;
        while ((mq.size() > 0 || bus.imem_resp_valid) && n < 20) begin step(); n++; end
        if (mq.size() > 0) check("drain_timeout", 64'd0, 64'd1);
        mem_lat = lat;
        bus.imem_req_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int n, c0, idx;
        logic [63:0] a0;
        tbl[0] = '{1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 64'h8000_0004, 1'b0, 64'h0};
        tbl[2] = '{1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[3] = '{1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
        tbl[4] = '{1'b1, 1'b1, 64'h8000_000C, 1'b0, 64'h0};
        tbl[5] = '{1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0008};
        tbl[6] = '{1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_000C};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            inst_ready = tbl[i].ready;
            step();
            check($sformatf("tbl%0d_rv", i), {63'd0, s_rv}, {63'd0, tbl[i].exp_rv});
            if (tbl[i].exp_rv) check($sformatf("tbl%0d_addr", i), s_addr, tbl[i].exp_addr);
            check($sformatf("tbl%0d_iv", i), {63'd0, s_iv}, {63'd0, tbl[i].exp_iv});
            if (tbl[i].exp_iv) check($sformatf("tbl%0d_ipc", i), s_ipc, tbl[i].exp_ipc);
        end

        // Core back-pressure: the IFU must fill exactly BUF_DEPTH slots and then stop.
        inst_ready = 1'b0;
        repeat (10) step();
        check("stall_req_valid", {63'd0, s_rv}, 64'd0);
        check("stall_inst_valid", {63'd0, s_iv}, 64'd1);
        check("stall_inflight", 64'(fires - consumed), 64'(DEPTH));
        inst_ready = 1'b1;
        c0 = consumed;
        repeat (12) step();
        check("stall_release", {63'd0, (consumed - c0) >= DEPTH}, 64'd1);

        // Request held while memory refuses it.
        bus.imem_req_ready = 1'b0;
        n = 0;
        step();
        while (!s_rv && n < 10) begin step(); n++; end
        a0 = s_addr;
        check("hold_first_addr", a0, nf_exp);
        repeat (3) begin
            step();
            check("hold_rv", {63'd0, s_rv}, 64'd1);
            check("hold_addr", s_addr, a0);
        end
        bus.imem_req_ready = 1'b1;

        // Redirect with two responses in flight (3-cycle memory).
        drain_mem(3);
        n = 0;
        while (!(mq.size() == 2 && !bus.imem_resp_valid) && n < 20) begin step(); n++; end
        check("two_in_flight", 64'(mq.size()), 64'd2);
        idx = fire_log.size();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0103;
        step();
        redirect_valid = 1'b0;
        wait_delivery("drain_first_pc", 64'h8000_0100, 40);
        if (fire_log.size() > idx) check("drain_first_req", fire_log[idx], 64'h8000_0100);
        else check("drain_no_req", 64'd0, 64'd1);

        // Redirect coincident with a response while an instruction is waiting.
        drain_mem(1);
        n = 0;
        while (!(bus.imem_resp_valid && inst_valid) && n < 20) begin step(); n++; end
        check("coinc_setup", {63'd0, bus.imem_resp_valid && inst_valid}, 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        wait_delivery("coinc_first_pc", 64'h8000_0200, 20);

        // PC wrap at the top of the address space.
        idx = fire_log.size();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_delivery("wrap_pc0", 64'hFFFF_FFFF_FFFF_FFFC, 20);
        wait_delivery("wrap_pc1", 64'h0, 20);
        if (fire_log.size() >= idx + 2) begin
            check("wrap_req0", fire_log[idx], 64'hFFFF_FFFF_FFFF_FFFC);
            check("wrap_req1", fire_log[idx + 1], 64'h0);
        end else check("wrap_req_missing", 64'd0, 64'd1);

`ifdef IFU_PERF_EN
        do_reset();
        repeat (100) begin
            bus.imem_req_ready = (fires < 20);
            inst_ready = !(stalls < 5 && inst_valid);
            step();
        end
        check("perf_bench_fires", 64'(fires), 64'd20);
        check("perf_bench_stalls", 64'(stalls), 64'd5);
        check("perf_fetch_cnt", perf_fetch_cnt, 64'd20);
        check("perf_stall_cnt", perf_stall_cnt, 64'd5);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
